// File: rtl/booth_shift_multiplier.sv
// booth_shift_multiplier
// Sequential shift-add multiplier retiring one multiplier bit per clock.
// signed_mode=0 runs plain unsigned shift-add; signed_mode=1 runs radix-2
// Booth on two's-complement operands. The product is held in {A,Q} and
// stays there after done until the next accepted start.

module booth_shift_multiplier #(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           n_reset,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   M,
   input  logic [N-1:0]   Qin,
   output logic [2*N-1:0] AQ,
   output logic           busy,
   output logic           done
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  m_reg;
   logic          mode_reg;
   logic [N-1:0]  a_reg;
   logic [N-1:0]  q_reg;
   logic          qm1;
   logic [CW-1:0] count;

   logic [N:0]    a_x;
   logic [N:0]    m_x;
   logic [N:0]    sum;
   logic [N-1:0]  a_nxt;
   logic [N-1:0]  q_nxt;
   logic          qm1_nxt;

   // One add-and-shift step. The sum is formed one bit wider than A; its top
   // bit is the unsigned carry or the signed extension bit, and it becomes
   // A's new MSB after the right shift, so no separate C/ext flop is needed.
   always_comb begin
      a_x     = mode_reg ? {a_reg[N-1], a_reg} : {1'b0, a_reg};
      m_x     = mode_reg ? {m_reg[N-1], m_reg} : {1'b0, m_reg};
      sum     = a_x;
      if (!mode_reg) begin
         if (q_reg[0]) sum = a_x + m_x;
      end else begin
         case ({q_reg[0], qm1})
            2'b01:   sum = a_x + m_x;
            2'b10:   sum = a_x - m_x;
            default: sum = a_x;
         endcase
      end
      a_nxt   = sum[N:1];
      q_nxt   = {sum[0], q_reg[N-1:1]};
      qm1_nxt = q_reg[0];
   end

   // Control FSM and datapath registers; reset abandons any operation.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         m_reg    <= '0;
         mode_reg <= 1'b0;
         a_reg    <= '0;
         q_reg    <= '0;
         qm1      <= 1'b0;
         count    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  m_reg    <= M;
                  mode_reg <= signed_mode;
                  a_reg    <= '0;
                  q_reg    <= Qin;
                  qm1      <= 1'b0;
                  count    <= CW'(N);
                  state    <= RUN;
               end else begin
                  state    <= IDLE;
               end
            end
            RUN: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               qm1   <= qm1_nxt;
               count <= count - CW'(1);
               if (count == CW'(1)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign AQ   = {a_reg, q_reg};
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_booth_shift_multiplier.sv
// tb_booth_shift_multiplier
// Directed test-plan cases on an N=8 instance plus randomized signed and
// unsigned operations on N=2, N=8 and N=16 instances, all compared against
// a plain-integer multiplication reference.

module tb_booth_shift_multiplier;

   logic        clock;
   logic        n_reset;
   logic [15:0] mbus;
   logic [15:0] qbus;
   logic        smb;
   logic [2:0]  st;

   logic [15:0] aq8;
   logic [3:0]  aq2;
   logic [31:0] aq16;
   logic [2:0]  bz;
   logic [2:0]  dn;

   int n_cmp = 0;
   int n_bad = 0;

   booth_shift_multiplier #(.N(8)) u_n8 (
      .clock(clock), .n_reset(n_reset), .start(st[0]), .signed_mode(smb),
      .M(mbus[7:0]), .Qin(qbus[7:0]), .AQ(aq8), .busy(bz[0]), .done(dn[0]));

   booth_shift_multiplier #(.N(2)) u_n2 (
      .clock(clock), .n_reset(n_reset), .start(st[1]), .signed_mode(smb),
      .M(mbus[1:0]), .Qin(qbus[1:0]), .AQ(aq2), .busy(bz[1]), .done(dn[1]));

   booth_shift_multiplier #(.N(16)) u_n16 (
      .clock(clock), .n_reset(n_reset), .start(st[2]), .signed_mode(smb),
      .M(mbus), .Qin(qbus), .AQ(aq16), .busy(bz[2]), .done(dn[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int width_of(int sel);
      case (sel)
         0:       return 8;
         1:       return 2;
         default: return 16;
      endcase
   endfunction

   task automatic sample(int sel, output logic [31:0] aq, output logic b, output logic d);
      case (sel)
         0:       aq = 32'(aq8);
         1:       aq = 32'(aq2);
         default: aq = aq16;
      endcase
      b = bz[sel];
      d = dn[sel];
   endtask

   // Reference: interpret operands as w-bit integers and multiply.
   function automatic logic [31:0] ref_mul(int w, logic [15:0] m, logic [15:0] q, logic sm);
      longint a, b, p, mask;
      mask = (longint'(1) << w) - 1;
      a = longint'(m) & mask;
      b = longint'(q) & mask;
      if (sm && a[w-1]) a = a - (longint'(1) << w);
      if (sm && b[w-1]) b = b - (longint'(1) << w);
      p = a * b;
      return 32'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Drive a request now; returns at the negedge after the accepting edge,
   // with operand buses scrambled to show they are no longer needed.
   task automatic launch(int sel, logic [15:0] m, logic [15:0] q, logic sm);
      mbus    = m;
      qbus    = q;
      smb     = sm;
      st[sel] = 1'b1;
      @(negedge clock);
      st[sel] = 1'b0;
      mbus    = 16'($urandom);
      qbus    = 16'($urandom);
      smb     = 1'($urandom);
   endtask

   // Wait for done (bounded), optionally poking start mid-run, then check
   // latency, busy duration and product. Returns in the DONE cycle.
   task automatic finish_op(int sel, string tag, logic [31:0] exp, bit poke);
      int          e;
      int          bc;
      int          w;
      logic [31:0] aq;
      logic        b;
      logic        d;
      w  = width_of(sel);
      e  = 0;
      bc = 0;
      sample(sel, aq, b, d);
      while (!d && e < 4 * w + 8) begin
         if (b) bc++;
         if (poke && e == 1) begin
            st[sel] = 1'b1;
            mbus    = 16'($urandom);
            qbus    = 16'($urandom);
            smb     = 1'($urandom);
         end else begin
            st[sel] = 1'b0;
         end
         @(negedge clock);
         e++;
         sample(sel, aq, b, d);
      end
      st[sel] = 1'b0;
      check({tag, " latency"}, 32'(e), 32'(w));
      check({tag, " busy cycles"}, 32'(bc), 32'(w));
      check({tag, " busy at done"}, 32'(b), 32'(0));
      check({tag, " product"}, aq, exp);
   endtask

   task automatic run_op(int sel, logic [15:0] m, logic [15:0] q, logic sm,
                         string tag, logic [31:0] exp, bit poke);
      @(negedge clock);
      launch(sel, m, q, sm);
      finish_op(sel, tag, exp, poke);
   endtask

   initial begin
      logic [31:0] aq;
      logic        b;
      logic        d;
      int          pulses;

      n_reset = 1'b0;
      st      = '0;
      mbus    = '0;
      qbus    = '0;
      smb     = 1'b0;
      repeat (2) @(negedge clock);
      for (int s = 0; s < 3; s++) begin
         sample(s, aq, b, d);
         check($sformatf("reset AQ N%0d", width_of(s)), aq, 32'(0));
         check($sformatf("reset busy N%0d", width_of(s)), 32'(b), 32'(0));
         check($sformatf("reset done N%0d", width_of(s)), 32'(d), 32'(0));
      end
      n_reset = 1'b1;

      // Unsigned basic case and product hold while idle.
      run_op(0, 16'd200, 16'd150, 1'b0, "u 200x150", 32'h7530, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         sample(0, aq, b, d);
         check($sformatf("hold AQ %0d", i), aq, 32'h7530);
         check($sformatf("hold done %0d", i), 32'(d), 32'(0));
      end

      run_op(0, 16'd255, 16'd255, 1'b0, "u max",  32'hFE01, 1'b0);
      run_op(0, 16'd0,   16'd173, 1'b0, "u zero", 32'h0000, 1'b0);
      run_op(0, 16'hFD,  16'h05,  1'b1, "s -3x5", 32'hFFF1, 1'b0);
      run_op(0, 16'h80,  16'h80,  1'b1, "s min^2", 32'h4000, 1'b0);
      run_op(0, 16'h7F,  16'h80,  1'b1, "s max*min", 32'hC080, 1'b0);

      // start pulsed mid-run with other operands must be ignored.
      run_op(0, 16'd200, 16'd150, 1'b0, "poke", 32'h7530, 1'b1);

      // Back-to-back: new start issued in the DONE cycle.
      run_op(0, 16'd13, 16'd11, 1'b0, "b2b first", 32'h008F, 1'b0);
      launch(0, 16'hF6, 16'h07, 1'b1);
      finish_op(0, "b2b second", 32'hFFBA, 1'b0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clock);
      launch(0, 16'd99, 16'd77, 1'b0);
      repeat (4) @(negedge clock);
      #2 n_reset = 1'b0;
      #1 sample(0, aq, b, d);
      check("midreset AQ", aq, 32'(0));
      check("midreset busy", 32'(b), 32'(0));
      check("midreset done", 32'(d), 32'(0));
      @(negedge clock);
      n_reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (dn[0]) pulses++;
      end
      check("no done after abort", 32'(pulses), 32'(0));
      run_op(0, 16'd12, 16'd10, 1'b0, "after reset", 32'h0078, 1'b0);

      // Randomized sweep with corner operands first for each width.
      for (int s = 0; s < 3; s++) begin
         int          w;
         int          cnt;
         logic [15:0] mn;
         logic [15:0] mxu;
         logic [15:0] mxs;
         logic [15:0] m;
         logic [15:0] q;
         logic        sm;
         w   = width_of(s);
         cnt = (s == 0) ? 300 : 1000;
         mn  = 16'(1 << (w - 1));
         mxu = 16'((1 << w) - 1);
         mxs = mn - 16'd1;
         for (int i = 0; i < cnt; i++) begin
            case (i)
               0:       begin m = mxu; q = mxu; sm = 1'b0; end
               1:       begin m = mn;  q = mn;  sm = 1'b1; end
               2:       begin m = mxs; q = mn;  sm = 1'b1; end
               3:       begin m = mxu; q = mxs; sm = 1'b1; end
               default: begin
                  m  = 16'($urandom);
                  q  = 16'($urandom);
                  sm = 1'($urandom);
               end
            endcase
            run_op(s, m, q, sm, $sformatf("rnd N%0d #%0d", w, i),
                   ref_mul(w, m, q, sm), ($urandom_range(0, 3) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
